hazard_ctrl: RTL

//  Generates the stall/flush controls consumed by id_ex_reg and the IF/PC stage.

---
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait hold and branch/jump flush.
// Define HAZARD_PERF_EN to add the perf_stalls / perf_flushes event counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 2,
  parameter logic [1:0]  WB_MEM    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instrn,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rdaddr,
  input  logic        ex_regwr,
  input  logic [1:0]  ex_wbsel,
  input  logic        ex_isbr,
  input  logic        ex_willjmp,
  input  logic        mem_busy,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes,
`endif
  output logic        stall,
  output logic        pc_hold,
  output logic        flush
);

  typedef enum logic [1:0] {IDLE, LDUSE, MEMWAIT, FLUSH} state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       ldhaz;
  logic       redirect;
  logic       unused_bits;

  assign rs1 = id_instrn[19:15];
  assign rs2 = id_instrn[24:20];

  // ex_willjmp alone marks a redirect; the branch flag and the remaining
  // instruction bits carry no extra information for this block.
  assign unused_bits = ^{ex_isbr, id_instrn[31:25], id_instrn[14:0]};

  assign ldhaz = ex_regwr && (ex_wbsel == WB_MEM) && (ex_rdaddr != 5'd0) &&
                 ((id_uses_rs1 && (rs1 == ex_rdaddr)) ||
                  (id_uses_rs2 && (rs2 == ex_rdaddr)));
  assign redirect = ex_willjmp;

  // Flush wins over a load-use stall; only a busy memory can stall alongside it.
  assign flush   = redirect || (state_reg == FLUSH);
  assign stall   = mem_busy ||
                   (!flush && ((state_reg == LDUSE) || ((state_reg == IDLE) && ldhaz)));
  assign pc_hold = stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (redirect) begin
            state_reg <= FLUSH;
            cnt_reg   <= 4'(FLUSH_CYC - 1);
          end else if (mem_busy) begin
            state_reg <= MEMWAIT;
          end else if (ldhaz && (LOAD_LAT > 1)) begin
            state_reg <= LDUSE;
            cnt_reg   <= 4'(LOAD_LAT - 1);
          end
        end
        LDUSE: begin
          if (redirect) begin
            state_reg <= FLUSH;
            cnt_reg   <= 4'(FLUSH_CYC - 1);
          end else if (mem_busy) begin
            state_reg <= MEMWAIT;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        MEMWAIT: begin
          if (!mem_busy) state_reg <= IDLE;
        end
        FLUSH: begin
          if (redirect) begin
            cnt_reg <= 4'(FLUSH_CYC - 1);
          end else if (cnt_reg == 4'd0) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stalls_reg;
  logic [31:0] perf_flushes_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stalls_reg  <= 32'd0;
      perf_flushes_reg <= 32'd0;
    end else begin
      if (stall) perf_stalls_reg <= perf_stalls_reg + 32'd1;
      if ((state_reg == IDLE) && redirect) perf_flushes_reg <= perf_flushes_reg + 32'd1;
    end
  end

  assign perf_stalls  = perf_stalls_reg;
  assign perf_flushes = perf_flushes_reg;
`endif

endmodule
